// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/hold sequencer for a 5-stage pipeline: load-use interlock,
// branch-taken flush, variable-latency data-memory hold with fatal timeout.
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             mem_branch_i,
  input  logic             mem_zero_i,
  input  logic             dm_req_i,
  input  logic             dm_ready_i,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic             pipe_hold_o,
  output logic             memwb_bubble_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  state_e            state_q, state_d;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;
  logic              err_q, err_d;

  logic taken_s, lu_s, mwait_s;
  logic pc_write_s, pc_src_s, ifid_write_s, ifid_flush_s;
  logic idex_flush_s, exmem_flush_s, hold_s, bubble_s;

  assign taken_s = mem_branch_i & mem_zero_i;
  assign lu_s    = ex_memread_i & (ex_rt_i != 5'd0) &
                   ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));
  assign mwait_s = dm_req_i & ~dm_ready_i;

  // Mealy decode of controls and next state; priority is mwait > taken > lu.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    stall_d       = stall_q;
    flush_d       = flush_q;
    err_d         = err_q;
    pc_write_s    = 1'b1;
    ifid_write_s  = 1'b1;
    pc_src_s      = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_flush_s  = 1'b0;
    exmem_flush_s = 1'b0;
    hold_s        = 1'b0;
    bubble_s      = 1'b0;
    case (state_q)
      ST_HALT: begin
        pc_write_s   = 1'b0;
        ifid_write_s = 1'b0;
        hold_s       = 1'b1;
        bubble_s     = 1'b1;
      end
      ST_RUN, ST_WAIT: begin
        if (mwait_s) begin
          pc_write_s   = 1'b0;
          ifid_write_s = 1'b0;
          hold_s       = 1'b1;
          bubble_s     = 1'b1;
          stall_d      = sat_inc(stall_q);
          if ((state_q == ST_WAIT) && (wait_q == TO_LAST)) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end else begin
            state_d = ST_WAIT;
            wait_d  = (state_q == ST_RUN) ? TO_W'(1) : wait_q + TO_W'(1);
          end
        end else if (taken_s) begin
          pc_src_s      = 1'b1;
          ifid_flush_s  = 1'b1;
          idex_flush_s  = 1'b1;
          exmem_flush_s = 1'b1;
          flush_d       = sat_inc(flush_q);
          state_d       = ST_RUN;
          wait_d        = '0;
        end else if (lu_s) begin
          pc_write_s   = 1'b0;
          ifid_write_s = 1'b0;
          idex_flush_s = 1'b1;
          stall_d      = sat_inc(stall_q);
          state_d      = ST_RUN;
          wait_d       = '0;
        end else begin
          state_d = ST_RUN;
          wait_d  = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  // State, wait counter, performance counters and sticky error.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end

  // Controls are forced low for as long as reset is asserted.
  assign pc_write_o     = rst_n & pc_write_s;
  assign pc_src_o       = rst_n & pc_src_s;
  assign ifid_write_o   = rst_n & ifid_write_s;
  assign ifid_flush_o   = rst_n & ifid_flush_s;
  assign idex_flush_o   = rst_n & idex_flush_s;
  assign exmem_flush_o  = rst_n & exmem_flush_s;
  assign pipe_hold_o    = rst_n & hold_s;
  assign memwb_bubble_o = rst_n & bubble_s;
  assign mem_err_o      = err_q;
  assign stall_cnt_o    = stall_q;
  assign flush_cnt_o    = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a wide-counter and a 2-bit-counter instance share
// stimulus and are checked every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, mem_branch, mem_zero, dm_req, dm_ready;

  logic        a_pcw, a_src, a_ifw, a_iff, a_idf, a_emf, a_hold, a_bub, a_err;
  logic [15:0] a_stall, a_flush;
  logic        b_pcw, b_src, b_ifw, b_iff, b_idf, b_emf, b_hold, b_bub, b_err;
  logic [1:0]  b_stall, b_flush;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16), .TO_W(8), .MEM_TIMEOUT(T)) dut_a (
    .clk_i(clk), .rst_n(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rt_i(id_uses_rt), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
    .mem_branch_i(mem_branch), .mem_zero_i(mem_zero), .dm_req_i(dm_req),
    .dm_ready_i(dm_ready), .pc_write_o(a_pcw), .pc_src_o(a_src),
    .ifid_write_o(a_ifw), .ifid_flush_o(a_iff), .idex_flush_o(a_idf),
    .exmem_flush_o(a_emf), .pipe_hold_o(a_hold), .memwb_bubble_o(a_bub),
    .mem_err_o(a_err), .stall_cnt_o(a_stall), .flush_cnt_o(a_flush));

  pipe_hazard_ctrl #(.CNT_W(2), .TO_W(8), .MEM_TIMEOUT(T)) dut_b (
    .clk_i(clk), .rst_n(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rt_i(id_uses_rt), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
    .mem_branch_i(mem_branch), .mem_zero_i(mem_zero), .dm_req_i(dm_req),
    .dm_ready_i(dm_ready), .pc_write_o(b_pcw), .pc_src_o(b_src),
    .ifid_write_o(b_ifw), .ifid_flush_o(b_iff), .idex_flush_o(b_idf),
    .exmem_flush_o(b_emf), .pipe_hold_o(b_hold), .memwb_bubble_o(b_bub),
    .mem_err_o(b_err), .stall_cnt_o(b_stall), .flush_cnt_o(b_flush));

  // Behavioural model: halted flag, length of current unbroken memory wait,
  // and unbounded event totals (saturation applied only when comparing).
  bit m_halt;
  int m_run, m_stalls, m_flushes;
  bit m_taken, m_lu, m_mwait;
  bit e_pcw, e_src, e_ifw, e_iff, e_idf, e_emf, e_hold, e_bub;

  assign m_taken = mem_branch && mem_zero;
  assign m_lu    = ex_memread && (ex_rt != 5'd0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign m_mwait = dm_req && !dm_ready;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always_comb begin
    {e_pcw, e_src, e_ifw, e_iff, e_idf, e_emf, e_hold, e_bub} = 8'd0;
    if (rst_n) begin
      e_pcw = 1'b1;
      e_ifw = 1'b1;
      if (m_halt || m_mwait) begin
        e_pcw = 1'b0; e_ifw = 1'b0; e_hold = 1'b1; e_bub = 1'b1;
      end else if (m_taken) begin
        e_src = 1'b1; e_iff = 1'b1; e_idf = 1'b1; e_emf = 1'b1;
      end else if (m_lu) begin
        e_pcw = 1'b0; e_ifw = 1'b0; e_idf = 1'b1;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_halt <= 1'b0; m_run <= 0; m_stalls <= 0; m_flushes <= 0;
    end else if (!m_halt) begin
      if (m_mwait) begin
        m_stalls <= m_stalls + 1;
        m_run    <= m_run + 1;
        if (m_run + 1 == T) m_halt <= 1'b1;
      end else begin
        m_run <= 0;
        if (m_taken) m_flushes <= m_flushes + 1;
        else if (m_lu) m_stalls <= m_stalls + 1;
      end
    end
  end

  // Every-cycle compare, mid-cycle on the falling edge.
  always @(negedge clk) begin
    chk("pc_write_a", int'(a_pcw), int'(e_pcw));   chk("pc_write_b", int'(b_pcw), int'(e_pcw));
    chk("pc_src_a", int'(a_src), int'(e_src));     chk("pc_src_b", int'(b_src), int'(e_src));
    chk("ifid_write_a", int'(a_ifw), int'(e_ifw)); chk("ifid_write_b", int'(b_ifw), int'(e_ifw));
    chk("ifid_flush_a", int'(a_iff), int'(e_iff)); chk("ifid_flush_b", int'(b_iff), int'(e_iff));
    chk("idex_flush_a", int'(a_idf), int'(e_idf)); chk("idex_flush_b", int'(b_idf), int'(e_idf));
    chk("exmem_flush_a", int'(a_emf), int'(e_emf)); chk("exmem_flush_b", int'(b_emf), int'(e_emf));
    chk("hold_a", int'(a_hold), int'(e_hold));     chk("hold_b", int'(b_hold), int'(e_hold));
    chk("bubble_a", int'(a_bub), int'(e_bub));     chk("bubble_b", int'(b_bub), int'(e_bub));
    chk("mem_err_a", int'(a_err), int'(m_halt));   chk("mem_err_b", int'(b_err), int'(m_halt));
    chk("stall_cnt_a", int'(a_stall), sat(m_stalls, 65535));
    chk("stall_cnt_b", int'(b_stall), sat(m_stalls, 3));
    chk("flush_cnt_a", int'(a_flush), sat(m_flushes, 65535));
    chk("flush_cnt_b", int'(b_flush), sat(m_flushes, 3));
  end

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; id_uses_rt = 1'b0; ex_memread = 1'b0;
    mem_branch = 1'b0; mem_zero = 1'b0; dm_req = 1'b0; dm_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int halt_cyc = 0;
  int burst = 0;

  initial begin
    rst_n = 1'b0;
    idle();
    next_cycle();
    @(negedge clk);
    chk("rst_pc_write", int'(a_pcw), 0);
    chk("rst_ifid_write", int'(a_ifw), 0);
    chk("rst_stall_cnt", int'(a_stall), 0);
    next_cycle(); rst_n = 1'b1;
    @(negedge clk);
    chk("run_pc_write", int'(a_pcw), 1);

    // load-use: lw $2 in EX, add rs=2 in ID
    next_cycle(); idle(); ex_memread = 1'b1; ex_rt = 5'd2; id_rs = 5'd2;
    @(negedge clk);
    chk("lu_pc_write", int'(a_pcw), 0);
    chk("lu_ifid_write", int'(a_ifw), 0);
    chk("lu_idex_flush", int'(a_idf), 1);
    next_cycle(); idle();
    @(negedge clk);
    chk("lu_stall_cnt", int'(a_stall), 1);
    chk("lu_model_stalls", m_stalls, 1);
    chk("lu_release", int'(a_pcw), 1);

    // load into $0 never stalls; rt match only counts if rt is read
    next_cycle(); idle(); ex_memread = 1'b1; id_uses_rt = 1'b1;
    @(negedge clk);
    chk("r0_pc_write", int'(a_pcw), 1);
    next_cycle(); idle(); ex_memread = 1'b1; ex_rt = 5'd3; id_rs = 5'd1; id_rt = 5'd3;
    @(negedge clk);
    chk("rt_unused_pc_write", int'(a_pcw), 1);
    next_cycle(); id_uses_rt = 1'b1;
    @(negedge clk);
    chk("rt_used_idex_flush", int'(a_idf), 1);

    // taken branch overrides load-use
    next_cycle(); idle(); ex_memread = 1'b1; ex_rt = 5'd2; id_rs = 5'd2;
    mem_branch = 1'b1; mem_zero = 1'b1;
    @(negedge clk);
    chk("br_pc_src", int'(a_src), 1);
    chk("br_pc_write", int'(a_pcw), 1);
    chk("br_ifid_flush", int'(a_iff), 1);
    chk("br_exmem_flush", int'(a_emf), 1);
    next_cycle(); idle();
    @(negedge clk);
    chk("br_flush_cnt", int'(a_flush), 1);
    chk("br_stall_cnt", int'(a_stall), 2);

    // three-cycle memory wait
    for (int i = 0; i < 3; i++) begin
      next_cycle(); idle(); dm_req = 1'b1;
      @(negedge clk);
      chk("mw_hold", int'(a_hold), 1);
      chk("mw_pc_write", int'(a_pcw), 0);
    end
    next_cycle(); dm_ready = 1'b1;
    @(negedge clk);
    chk("mw_release_hold", int'(a_hold), 0);
    chk("mw_release_pc_write", int'(a_pcw), 1);
    next_cycle(); idle();
    @(negedge clk);
    chk("mw_stall_cnt", int'(a_stall), 5);
    chk("mw_stall_cnt_sat", int'(b_stall), 3);

    // branch waiting in MEM during a two-cycle wait
    for (int i = 0; i < 2; i++) begin
      next_cycle(); idle(); dm_req = 1'b1; mem_branch = 1'b1; mem_zero = 1'b1;
      @(negedge clk);
      chk("wt_pc_src_early", int'(a_src), 0);
      chk("wt_exmem_early", int'(a_emf), 0);
    end
    next_cycle(); dm_ready = 1'b1;
    @(negedge clk);
    chk("wt_pc_src", int'(a_src), 1);
    chk("wt_ifid_flush", int'(a_iff), 1);
    chk("wt_hold", int'(a_hold), 0);
    next_cycle(); idle();
    @(negedge clk);
    chk("wt_flush_cnt", int'(a_flush), 2);
    chk("wt_stall_cnt", int'(a_stall), 7);

    // timeout after four unbroken wait cycles
    for (int i = 0; i < 4; i++) begin
      next_cycle(); idle(); dm_req = 1'b1;
      @(negedge clk);
      chk("to_err_pending", int'(a_err), 0);
    end
    next_cycle(); dm_ready = 1'b1; mem_branch = 1'b1; mem_zero = 1'b1;
    @(negedge clk);
    chk("to_err_a", int'(a_err), 1);
    chk("to_err_b", int'(b_err), 1);
    chk("halt_hold", int'(a_hold), 1);
    chk("halt_pc_src", int'(a_src), 0);
    chk("halt_stall_cnt", int'(a_stall), 11);
    next_cycle();
    @(negedge clk);
    chk("halt_stall_frozen", int'(a_stall), 11);
    chk("halt_flush_frozen", int'(a_flush), 2);
    next_cycle(); rst_n = 1'b0;
    @(negedge clk);
    chk("rst_err", int'(a_err), 0);
    chk("rst_pc_write_halt", int'(a_pcw), 0);
    chk("rst_hold", int'(a_hold), 0);
    chk("rst_flush_cnt", int'(a_flush), 0);
    next_cycle(); rst_n = 1'b1; idle();
    @(negedge clk);
    chk("post_rst_pc_write", int'(a_pcw), 1);

    // randomized traffic on a small register set so hazards collide often
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      halt_cyc = m_halt ? halt_cyc + 1 : 0;
      if (!rst_n) rst_n = 1'b1;
      else if (($urandom_range(0, 299) == 0) || (halt_cyc > 3)) rst_n = 1'b0;
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      ex_rt      = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom_range(0, 1));
      ex_memread = ($urandom_range(0, 2) == 0);
      mem_branch = ($urandom_range(0, 3) == 0);
      mem_zero   = 1'($urandom_range(0, 1));
      if (burst == 0 && $urandom_range(0, 39) == 0) burst = 6;
      if (burst > 0) begin
        burst--;
        dm_req   = 1'b1;
        dm_ready = ($urandom_range(0, 4) == 0);
      end else begin
        dm_req   = ($urandom_range(0, 9) < 3);
        dm_ready = ($urandom_range(0, 9) < 6);
      end
    end
    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/hold sequencer for the 5-stage pipelined CPU (IF, ID, EX, MEM, WB).
- Watches the ID and EX register fields, the branch outcome in MEM, and a variable-latency data-memory handshake.
- Drives PC write-enable, the PC-source select, per-register flush/hold controls, a memory-timeout error and performance counters.
- Sits beside the pipeline registers. The pipeline registers are not modified; they gain write-enable/flush inputs driven from this block.

Parameters:
- CNT_W, 16, width of the saturating stall/flush performance counters.
- TO_W, 8, width of the memory wait counter.
- MEM_TIMEOUT, 200, number of consecutive wait cycles before a fatal timeout; must be ≤ 2^TO_W−1.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs_i  in  5  rs field of the instruction in IF/ID.
- id_rt_i  in  5  rt field of the instruction in IF/ID.
- id_uses_rt_i  in  1  ID instruction reads rt (R-type, beq, sw).
- ex_memread_i  in  1  MemRead held in ID/EX.
- ex_rt_i  in  5  rt (load destination) held in ID/EX.
- mem_branch_i  in  1  Branch held in EX/MEM.
- mem_zero_i  in  1  ALU zero held in EX/MEM.
- dm_req_i  in  1  MEM stage performs a data-memory access this cycle.
- dm_ready_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC load enable.
- pc_src_o  out  1  1 = PC loads the branch target.
- ifid_write_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  zero IF/ID on the next edge.
- idex_flush_o  out  1  zero ID/EX control bits on the next edge (bubble).
- exmem_flush_o  out  1  zero EX/MEM control bits on the next edge.
- pipe_hold_o  out  1  ID/EX and EX/MEM keep their contents.
- memwb_bubble_o  out  1  MEM/WB loads zero control bits.
- mem_err_o  out  1  sticky memory timeout flag.
- stall_cnt_o  out  CNT_W  count of stall cycles (load-use + memory wait).
- flush_cnt_o  out  CNT_W  count of branch flush events.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk_i, rst_n).
- Reset (rst_n=0, immediate):
  - state=RUN; wait_cnt=0; counters=0; mem_err_o=0.
  - All combinational outputs are forced to 0 while rst_n=0.
- FSM states: RUN, MEM_WAIT, HALT. Outputs are Mealy (state + current inputs). Signals not listed in a case are 0; pc_write_o and ifid_write_o default to 1.
- Hazard terms:
  - taken = mem_branch_i & mem_zero_i.
  - lu = ex_memread_i & (ex_rt_i≠0) & ((ex_rt_i==id_rs_i) | (id_uses_rt_i & ex_rt_i==id_rt_i)).
  - mwait = dm_req_i & ~dm_ready_i.
- RUN / MEM_WAIT, evaluated in strict priority order:
  1. mwait:
     - pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, memwb_bubble_o=1.
     - Next state MEM_WAIT; wait_cnt+1 (wait_cnt is 0 when entering from RUN); stall_cnt+1.
  2. taken:
     - pc_src_o=1, pc_write_o=1, ifid_flush_o=1, idex_flush_o=1, exmem_flush_o=1.
     - flush_cnt+1; next state RUN; wait_cnt=0; lu is ignored.
  3. lu:
     - pc_write_o=0, ifid_write_o=0, idex_flush_o=1.
     - stall_cnt+1; next state RUN.
  4. Otherwise: normal advance; next state RUN; wait_cnt=0.
- Memory completion:
  - The cycle dm_ready_i=1 arrives while in MEM_WAIT is a normal step: hold is released and cases 2–4 apply in that same cycle (the branch is still in MEM).
  - Back-to-back accesses re-enter MEM_WAIT with wait_cnt reset to 0.
- Timeout:
  - In MEM_WAIT, if mwait holds and wait_cnt==MEM_TIMEOUT−1, next state is HALT and mem_err_o=1.
  - HALT: pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, memwb_bubble_o=1. Exit only by reset; mem_err_o stays 1.
- Counters saturate at 2^CNT_W−1 (no wrap). They do not count in HALT.
- A load whose rt=0 never stalls. A reset mid-wait returns to RUN immediately.

Test Plan:
- Load-use: lw $2 in EX (ex_memread=1, ex_rt=2), add rs=2 in ID → exactly 1 cycle with pc_write=0, ifid_write=0, idex_flush=1; stall_cnt=1.
- Branch taken: mem_branch=1, mem_zero=1 together with an active lu → pc_src=1 and all three flushes=1, no stall; flush_cnt=1.
- Memory wait: dm_req=1, dm_ready low for 3 cycles then high → 3 cycles of hold/bubble, release on cycle 4; stall_cnt=3.
- Wait then taken: branch in MEM during a 2-cycle wait → flushes and pc_src appear only in the dm_ready cycle; flush_cnt=1.
- Timeout: MEM_TIMEOUT=4, dm_ready never asserted → mem_err=1 after 4 wait cycles; state HALT persists until rst_n pulse, then all outputs clear.
- Saturation: CNT_W=2, 5 load-use stalls → stall_cnt_o=3.
